// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : 5-stage pipeline hazard controller: operand forwarding, load-use
//            bubbles, data-memory wait freezing, stall counter, timeout halt.
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic             use_rs,
    input  logic             use_rt,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [4:0]       edestReg,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic             mwmem,
    input  logic [4:0]       mdestReg,
    input  logic             dmem_ack,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic             dmem_req,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             err
);

    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] C_TIMEOUT = WAIT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_MWAIT = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;

    logic w_memop;
    logic w_lu;
    logic w_stalled;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] x,
        input logic       use_x,
        input logic       e_wreg,
        input logic       e_m2reg,
        input logic [4:0] e_dest,
        input logic       m_wreg,
        input logic       m_m2reg,
        input logic [4:0] m_dest
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (use_x && (x != 5'd0)) begin
            if (e_wreg && !e_m2reg && (e_dest == x))
                sel = 2'd1;
            else if (m_wreg && (m_dest == x))
                sel = m_m2reg ? 2'd3 : 2'd2;
        end
        return sel;
    endfunction

    assign w_memop = mwmem | (mwreg & mm2reg);
    assign w_lu    = ewreg & em2reg & (edestReg != 5'd0) &
                     ((use_rs & (edestReg == rs)) | (use_rt & (edestReg == rt)));

    always_comb begin
        fwda         = 2'd0;
        fwdb         = 2'd0;
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b0;
        memwb_bubble = 1'b0;
        dmem_req     = 1'b0;
        if (!rst) begin
            fwda = fwd_sel(rs, use_rs, ewreg, em2reg, edestReg, mwreg, mm2reg, mdestReg);
            fwdb = fwd_sel(rt, use_rt, ewreg, em2reg, edestReg, mwreg, mm2reg, mdestReg);
            case (r_state)
                S_RUN, S_MWAIT: begin
                    dmem_req = (r_state == S_MWAIT) ? 1'b1 : w_memop;
                    // Frozen whenever a memory op is outstanding; freeze beats lu.
                    if ((r_state == S_MWAIT || w_memop) && !dmem_ack) begin
                        memwb_bubble = 1'b1;
                    end else if (w_lu) begin
                        idex_en     = 1'b1;
                        idex_bubble = 1'b1;
                        exmem_en    = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                    end
                end
                S_HALT:  memwb_bubble = 1'b1;
                default: memwb_bubble = 1'b1;
            endcase
        end
    end

    assign w_stalled = !pc_en || !exmem_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
            r_wait  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_stalled && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + 1'b1;
            case (r_state)
                S_RUN: begin
                    if (w_memop && !dmem_ack) begin
                        r_state <= S_MWAIT;
                        r_wait  <= WAIT_W'(1);
                    end
                end
                S_MWAIT: begin
                    // r_wait counts MWAIT cycles including the current one.
                    if (dmem_ack) begin
                        r_state <= S_RUN;
                        r_wait  <= '0;
                    end else if (r_wait == C_TIMEOUT) begin
                        r_state <= S_HALT;
                        r_err   <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_HALT;
            endcase
        end
    end

    assign stall_cnt = r_cnt;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Scoreboard bench for pipe_hazard_ctrl with a reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       ewreg;
        logic       em2reg;
        logic [4:0] edest;
        logic       mwreg;
        logic       mm2reg;
        logic       mwmem;
        logic [4:0] mdest;
        logic       ack;
    } stim_t;

    logic             clk;
    logic             rst;
    logic [4:0]       rs, rt, edestReg, mdestReg;
    logic             use_rs, use_rt, ewreg, em2reg, mwreg, mm2reg, mwmem, dmem_ack;
    logic [1:0]       fwda, fwdb;
    logic             pc_en, ifid_en, idex_en, idex_bubble, exmem_en, memwb_bubble;
    logic             dmem_req, err;
    logic [CNT_W-1:0] stall_cnt;

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
        .ewreg(ewreg), .em2reg(em2reg), .edestReg(edestReg), .mwreg(mwreg),
        .mm2reg(mm2reg), .mwmem(mwmem), .mdestReg(mdestReg), .dmem_ack(dmem_ack),
        .fwda(fwda), .fwdb(fwdb), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .idex_bubble(idex_bubble), .exmem_en(exmem_en), .memwb_bubble(memwb_bubble),
        .dmem_req(dmem_req), .stall_cnt(stall_cnt), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] exp_q[$];
    int          cyc_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          pushed   = 0;
    int          popped   = 0;

    // Reference model state: mode 0 = running, 1 = waiting on memory, 2 = halted.
    int m_mode = 0;
    int m_wait = 0;
    int m_cnt  = 0;
    bit m_err  = 0;
    int cyc    = 0;

    function automatic int fwd_ref(int x, bit use_x, stim_t s);
        if (!use_x || x == 0) return 0;
        if (s.ewreg && !s.em2reg && int'(s.edest) == x) return 1;
        if (s.mwreg && int'(s.mdest) == x) return s.mm2reg ? 3 : 2;
        return 0;
    endfunction

    task automatic model(input stim_t s, output logic [15:0] e);
        int  fa, fb;
        bit  memop, lu, frozen;
        bit  pc, ifid, idex, idexb, exm, mwb, req;
        fa = 0; fb = 0; pc = 0; ifid = 0; idex = 0; idexb = 0; exm = 0; mwb = 0; req = 0;
        memop  = s.mwmem || (s.mwreg && s.mm2reg);
        lu     = s.ewreg && s.em2reg && s.edest != 0 &&
                 ((s.use_rs && s.edest == s.rs) || (s.use_rt && s.edest == s.rt));
        frozen = 0;
        if (!s.rst) begin
            fa = fwd_ref(int'(s.rs), s.use_rs, s);
            fb = fwd_ref(int'(s.rt), s.use_rt, s);
            if (m_mode == 2) frozen = 1;
            else begin
                req    = (m_mode == 1) ? 1'b1 : memop;
                frozen = (m_mode == 1 || memop) && !s.ack;
            end
            if (frozen) mwb = 1;
            else if (lu) begin idex = 1; idexb = 1; exm = 1; end
            else begin pc = 1; ifid = 1; idex = 1; exm = 1; end
        end
        e = {fa[1:0], fb[1:0], pc, ifid, idex, idexb, exm, mwb, req, m_err, m_cnt[CNT_W-1:0]};
        if (s.rst) begin
            m_mode = 0; m_wait = 0; m_cnt = 0; m_err = 0;
        end else begin
            if ((!pc || !exm) && m_cnt < CNT_MAX) m_cnt++;
            if (m_mode == 0 && memop && !s.ack) begin
                m_mode = 1; m_wait = 1;
            end else if (m_mode == 1) begin
                if (s.ack) begin m_mode = 0; m_wait = 0; end
                else if (m_wait >= TIMEOUT) begin m_mode = 2; m_err = 1; end
                else m_wait++;
            end
        end
    endtask

    task automatic step(input stim_t s);
        logic [15:0] e;
        rst = s.rst; rs = s.rs; rt = s.rt; use_rs = s.use_rs; use_rt = s.use_rt;
        ewreg = s.ewreg; em2reg = s.em2reg; edestReg = s.edest;
        mwreg = s.mwreg; mm2reg = s.mm2reg; mwmem = s.mwmem; mdestReg = s.mdest;
        dmem_ack = s.ack;
        model(s, e);
        exp_q.push_back(e);
        cyc_q.push_back(cyc);
        pushed++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst    = ($urandom_range(0, 59) == 0);
        s.rs     = 5'($urandom_range(0, 3));
        s.rt     = 5'($urandom_range(0, 3));
        s.use_rs = ($urandom_range(0, 3) != 0);
        s.use_rt = ($urandom_range(0, 3) != 0);
        s.ewreg  = 1'($urandom_range(0, 1));
        s.em2reg = 1'($urandom_range(0, 1));
        s.edest  = 5'($urandom_range(0, 3));
        s.mwreg  = 1'($urandom_range(0, 1));
        s.mm2reg = ($urandom_range(0, 2) == 0);
        s.mwmem  = ($urandom_range(0, 3) == 0);
        s.mdest  = 5'($urandom_range(0, 3));
        s.ack    = ($urandom_range(0, 4) < 2);
        return s;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [15:0] e, a;
            int          c;
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            popped++;
            a = {fwda, fwdb, pc_en, ifid_en, idex_en, idex_bubble, exmem_en,
                 memwb_bubble, dmem_req, err, stall_cnt};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL cyc=%0d outputs {fwda,fwdb,pc,ifid,idex,idexb,exm,mwbb,req,err,cnt} got=%b required=%b",
                         c, a, e);
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1; rs = '0; rt = '0; use_rs = 0; use_rt = 0; ewreg = 0; em2reg = 0;
        edestReg = '0; mwreg = 0; mm2reg = 0; mwmem = 0; mdestReg = '0; dmem_ack = 0;
        @(posedge clk);
        #1;
        s = idle(); s.rst = 1; s.ack = 1; s.mwmem = 1; s.use_rs = 1; s.rs = 5;
        s.ewreg = 1; s.edest = 5;
        step(s);
        // Forwarding priority and register-0 / use-bit gating
        s = idle(); s.rs = 5; s.use_rs = 1; s.ewreg = 1; s.edest = 5; s.mwreg = 1; s.mdest = 5;
        step(s);
        s.edest = 0;
        step(s);
        s = idle(); s.rt = 7; s.use_rt = 1; s.mwreg = 1; s.mm2reg = 1; s.mdest = 7; s.ack = 1;
        step(s);
        s.use_rt = 0;
        step(s);
        s = idle(); s.rs = 0; s.use_rs = 1; s.mwreg = 1; s.mdest = 0;
        step(s);
        // Load-use bubble, then load data forwarded from MEM
        s = idle(); s.rs = 3; s.use_rs = 1; s.ewreg = 1; s.em2reg = 1; s.edest = 3;
        step(s);
        s = idle(); s.rs = 3; s.use_rs = 1; s.mwreg = 1; s.mm2reg = 1; s.mdest = 3; s.ack = 1;
        step(s);
        // Store with three wait cycles, lu pending throughout
        s = idle(); s.mwmem = 1; s.rs = 2; s.use_rs = 1; s.ewreg = 1; s.em2reg = 1; s.edest = 2;
        repeat (3) step(s);
        s.ack = 1;
        step(s);
        s = idle(); s.mwmem = 1; s.ack = 1;
        step(s);
        // Timeout into HALT, saturate counter, then reset
        s = idle(); s.mwmem = 1;
        repeat (24) step(s);
        s = idle(); s.rst = 1;
        step(s);
        s = idle();
        step(s);
        for (int i = 0; i < 3000; i++) step(rand_stim());
        @(negedge clk);
        #1;
        checks++;
        if (popped != pushed || exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain popped=%0d required=%0d", popped, pushed);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
